// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA fill a byte FIFO that a
// baud-paced serializer drains; STATUS is readable combinationally on the load path.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        sysclk,
  input  logic        cpu_resetn,
  input  logic        is_store,
  input  logic [5:0]  alucode,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data_word,
  input  logic [31:0] r_addr,
  output logic [31:0] r_data,
  output logic        r_hit,
  output logic        uart_tx,
  output logic        irq_tx_empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;
  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [PTR_W-1:0] DEPTH_CNT   = PTR_W'(FIFO_DEPTH);
  localparam logic [31:0]      TXDATA_ADDR = BASE_ADDR;
  localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [5:0]       OP_SB       = 6'd14;
  localparam logic [5:0]       OP_SH       = 6'd15;
  localparam logic [5:0]       OP_SW       = 6'd16;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         fifo_mem [FIFO_DEPTH];

  logic               store_op;
  logic               push_req;
  logic               clr_req;
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               baud_last;
  logic [7:0]         head;
  logic [31:0]        status;
  logic               unused_wdata;

  // Only the low byte is transmitted and bit 3 clears overflow; the rest is ignored.
  assign unused_wdata = ^w_data_word[31:8];

  assign store_op = is_store && (alucode == OP_SB || alucode == OP_SH || alucode == OP_SW);
  assign push_req = store_op && (w_addr == TXDATA_ADDR);
  assign clr_req  = store_op && (w_addr == STATUS_ADDR) && w_data_word[3];

  assign count = wptr_q - rptr_q;
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = push_req && !full;
  assign head  = fifo_mem[rptr_q[IDX_W-1:0]];

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
    // A dropped push outranks a same-cycle clear so no overflow goes unreported.
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (clr_req) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (!cpu_resetn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge sysclk) begin
    if (cpu_resetn && push) begin
      fifo_mem[wptr_q[IDX_W-1:0]] <= w_data_word[7:0];
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = (state_q != S_IDLE);
    status[1]     = full;
    status[2]     = empty;
    status[3]     = ovf_q;
    status[15:8]  = 8'(count);
  end

  assign r_hit        = (r_addr[31:3] == BASE_ADDR[31:3]);
  assign r_data       = (r_addr == STATUS_ADDR) ? status : '0;
  assign uart_tx      = tx_q;
  assign irq_tx_empty = empty && (state_q == S_IDLE);

endmodule
